multimode_ring_counter: RTL
===========================

# multimode_ring_counter

Parametrised successor to the team's fixed 4-bit ring counter. It generates a WIDTH-bit ring (one-hot) or Johnson (twisted-ring) sequence, with the following run-time controls:
- enable;
- direction;
- mode select;
- synchronous seed load with legality checking;
- self-correction of illegal states.

It drives one-hot/Johnson phase enables for sequencers and scanners, and reports a decoded position, a wrap pulse and an error pulse.

## Interface
Parameters:
- WIDTH, 4, counter width; legal range 2..32.
- PW, $clog2(2*WIDTH), width of pos (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  advance one step per cycle when high.
- dir  in  1  0 = shift toward MSB; 1 = shift toward LSB.
- mode  in  1  0 = ring (one-hot); 1 = Johnson.
- load  in  1  synchronous load of load_val.
- load_val  in  WIDTH  seed for load.
- Qn  out  WIDTH  counter state (registered).
- pos  out  PW  steps from start state, modulo period (registered).
- wrap  out  1  one-cycle pulse: a step just reached the start state (registered).
- err  out  1  one-cycle pulse: illegal load rejected, or illegal state corrected (registered).

## Operation
Start state and period by mode:
- Ring: start = 0..01, period = WIDTH.
- Johnson: start = 0..00, period = 2*WIDTH.

Step functions:
- Ring, dir=0: Qn <= {Qn[W-2:0], Qn[W-1]}.
- Ring, dir=1: Qn <= {Qn[0], Qn[W-1:1]}.
- Johnson, dir=0: Qn <= {Qn[W-2:0], ~Qn[W-1]}.
- Johnson, dir=1: Qn <= {~Qn[0], Qn[W-1:1]}.

Legal states:
- Ring: exactly one bit set.
- Johnson: the bits form one contiguous run, either ones in the LSBs (0..01..1, including all-0) or ones in the MSBs (1..10..0, including all-1).

pos tracking:
- A dir=0 step increments pos modulo period; a dir=1 step decrements it modulo period.
- On load, pos takes the decoded index of load_val:
  - Ring: index of the set bit.
  - Johnson: k ones in the LSBs → k; otherwise (ones in the MSBs) → WIDTH + number of zeros.

An internal register mode_q holds the last accepted mode.

Priority per clock edge, highest first:
1. rst: Qn=0..01, pos=0, mode_q=0, wrap=0, err=0 (asynchronous).
2. mode != mode_q: mode_q<=mode, Qn<=start(mode), pos<=0, wrap<=0, err<=0. load and en are ignored this cycle.
3. load with load_val legal for mode: Qn<=load_val, pos<=decoded index, wrap<=0, err<=0.
4. load with illegal load_val: Qn<=start, pos<=0, err<=1, wrap<=0.
5. en with Qn illegal (e.g. upset): Qn<=start, pos<=0, err<=1, wrap<=0.
6. en with Qn legal: step per mode/dir. wrap<=1 iff the next Qn equals start; err<=0.
7. otherwise: hold Qn and pos; wrap<=0, err<=0.

Additional rules:
- dir may change on any cycle. The next step uses the new direction from the current state; no re-initialisation.
- When en is low and Qn is illegal, Qn holds. Correction happens only on the next enabled step.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Step latency: the edge at which en=1 is sampled updates Qn, pos and wrap together.
- wrap and err are high for exactly one cycle per triggering edge. When en is held high, wrap repeats every period cycles.
- After deassertion of rst, the first edge applies priority 2 if mode=1. Johnson operation therefore starts from 0..00 one cycle after reset release.
- Asserting rst mid-sequence takes effect immediately and asynchronously. No partial step completes.
- A mode change takes one cycle during which en is ignored. The first step in the new mode occurs on the following edge.

## Test plan
- WIDTH=4, mode=0, dir=0, en=1 from reset: Qn = 0001, 0010, 0100, 1000, 0001. pos = 0, 1, 2, 3, 0. wrap=1 only on the edge that returns Qn to 0001.
- WIDTH=4, mode=1, dir=0, en=1: the first edge re-initialises to 0000. Qn then runs 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, with pos 1..7 and then 0. wrap=1 once per 8 steps.
- Direction reversal, ring at 0100 (pos=2): dir=1 for two steps → 0010, 0001, with pos 1, 0 and wrap=1 on reaching 0001. Then dir=0 for one step → 0010, pos=1.
- Load, WIDTH=4:
  - mode=1, load_val=1100 → Qn=1100, pos=6, err=0.
  - mode=1, load_val=1010 → Qn=0000, pos=0, err=1 for one cycle.
  - mode=0, load_val=0110 → Qn=0001, err=1.
- Self-correction and priority: force Qn=0101 in ring mode with en=0 → Qn holds 0101, err=0. Set en=1 → Qn=0001, pos=0, err=1. With load=1 and a mode change in the same cycle, the mode change wins.
- Async reset mid-count: in Johnson mode at 0111, assert rst between clock edges → Qn=0001, pos=0, wrap=0 and err=0 immediately. After release with mode=1, the next edge gives Qn=0000.

Source files
------------

// File: rtl/multimode_ring_counter.sv
// multimode_ring_counter
//   WIDTH-bit ring (one-hot) or Johnson (twisted-ring) sequencer. It supports
//   the following controls:
//     - enable and direction;
//     - run-time mode select;
//     - synchronous seed load with a legality check;
//     - self-correction of illegal (e.g. upset) states on the next enabled step.
//   Ports:
//     clk, rst   clock, asynchronous active-high reset
//     en         advance one step this cycle
//     dir        0 = shift toward MSB (pos++), 1 = shift toward LSB (pos--)
//     mode       0 = ring, 1 = Johnson
//     load       load load_val (if legal for the current mode)
//     load_val   seed value
//     Qn         registered counter state
//     pos        registered position (steps from start state, mod period)
//     wrap       one-cycle pulse when a step lands on the start state
//     err        one-cycle pulse on rejected load or corrected illegal state
module multimode_ring_counter #(
  parameter int WIDTH = 4,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Qn,
  output logic [PW-1:0]    pos,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH-1:0] RING_START = WIDTH'(1);
  localparam logic [WIDTH-1:0] JOHN_START = '0;
  localparam logic [PW-1:0]    RING_LAST  = PW'(WIDTH-1);
  localparam logic [PW-1:0]    JOHN_LAST  = PW'(2*WIDTH-1);

  // Ring: exactly one bit set. Johnson: ones packed into the LSBs (v+1 clears
  // them all) or into the MSBs (same test on the complement).
  function automatic logic is_legal(input logic md, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] nv;
    nv = ~v;
    if (!md) return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
  endfunction

  // Position of a legal value. Johnson MSB-run: WIDTH + zeros = 2*WIDTH - ones.
  function automatic logic [PW-1:0] decode(input logic md, input logic [WIDTH-1:0] v);
    logic [PW-1:0] idx;
    logic [PW-1:0] ones;
    idx  = '0;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx  = PW'(i);
        ones = ones + PW'(1);
      end
    end
    if (!md) return idx;
    if ((v & (v + WIDTH'(1))) == '0) return ones;
    return PW'(2*WIDTH) - ones;
  endfunction

  logic [WIDTH-1:0] qn_q, qn_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] start_new, start_cur, nxt;
  logic [PW-1:0]    last;
  logic             fb_up, fb_dn;

  always_comb begin
    start_new = mode   ? JOHN_START : RING_START;
    start_cur = mode_q ? JOHN_START : RING_START;
    last      = mode_q ? JOHN_LAST  : RING_LAST;
    // Johnson inverts the bit that wraps around; ring passes it straight.
    fb_up     = qn_q[WIDTH-1] ^ mode_q;
    fb_dn     = qn_q[0] ^ mode_q;
    nxt       = dir ? {fb_dn, qn_q[WIDTH-1:1]} : {qn_q[WIDTH-2:0], fb_up};

    mode_d = mode_q;
    qn_d   = qn_q;
    pos_d  = pos_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;

    if (mode != mode_q) begin
      mode_d = mode;
      qn_d   = start_new;
      pos_d  = '0;
    end else if (load) begin
      if (is_legal(mode_q, load_val)) begin
        qn_d  = load_val;
        pos_d = decode(mode_q, load_val);
      end else begin
        qn_d  = start_cur;
        pos_d = '0;
        err_d = 1'b1;
      end
    end else if (en) begin
      if (!is_legal(mode_q, qn_q)) begin
        qn_d  = start_cur;
        pos_d = '0;
        err_d = 1'b1;
      end else begin
        qn_d   = nxt;
        wrap_d = (nxt == start_cur);
        if (dir) pos_d = (pos_q == '0)  ? last : pos_q - PW'(1);
        else     pos_d = (pos_q == last) ? '0  : pos_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qn_q   <= RING_START;
      pos_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      qn_q   <= qn_d;
      pos_q  <= pos_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign Qn   = qn_q;
  assign pos  = pos_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule
